// File: rtl/ttl_mux_reg.sv
// ttl_mux_reg
//   Registered N-channel, W-bit multiplexer with a channel pointer that is
//   either loaded from a select bus or stepped round-robin (scan mode).
//   Used to time-multiplex several sources onto one shared bus.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   In     in   packed channels; channel k is In[k*WIDTH +: WIDTH]
//   Sel    in   channel to load into the pointer
//   Load   in   load pointer from Sel this cycle
//   Scan   in   step pointer this cycle (wraps at CHANNELS-1)
//   Hold   in   freeze pointer and Out this cycle
//   G_n    in   active-low output strobe; when high, Out is forced low
//   Out    out  registered selected data
//   Ch     out  current pointer value
//   Wrap   out  one-cycle pulse when a scan step wraps to channel 0
//   Err    out  one-cycle pulse when Load is requested with Sel >= CHANNELS
module ttl_mux_reg #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   In,
  input  logic [SEL_BITS-1:0]         Sel,
  input  logic                        Load,
  input  logic                        Scan,
  input  logic                        Hold,
  input  logic                        G_n,
  output logic [WIDTH-1:0]            Out,
  output logic [SEL_BITS-1:0]         Ch,
  output logic                        Wrap,
  output logic                        Err
);

  // One extra bit so CHANNELS == 2**SEL_BITS is still representable.
  localparam logic [SEL_BITS:0]   LP_CHANNELS = (SEL_BITS+1)'(CHANNELS);
  localparam logic [SEL_BITS-1:0] LP_LAST     = SEL_BITS'(CHANNELS - 1);

  logic [WIDTH-1:0]    r_out;
  logic [SEL_BITS-1:0] r_ch;
  logic                r_wrap;
  logic                r_err;

  logic [WIDTH-1:0]    w_sel_data;
  logic                w_sel_valid;

  // Explicit compare loop keeps the mux in range for non-power-of-two
  // channel counts; r_ch never exceeds CHANNELS-1 anyway.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_ch == SEL_BITS'(k)) begin
        w_sel_data = In[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_valid = ({1'b0, Sel} < LP_CHANNELS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= '0;
      r_ch   <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (!Hold) begin
        // Data uses the pointer value from before this edge's update.
        r_out <= G_n ? '0 : w_sel_data;
        if (Load) begin
          // A rejected load still suppresses scanning for the cycle.
          if (w_sel_valid) begin
            r_ch <= Sel;
          end else begin
            r_err <= 1'b1;
          end
        end else if (Scan) begin
          if (r_ch == LP_LAST) begin
            r_ch   <= '0;
            r_wrap <= 1'b1;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
      end
    end
  end

  assign Out  = r_out;
  assign Ch   = r_ch;
  assign Wrap = r_wrap;
  assign Err  = r_err;

endmodule

// File: tb/tb_ttl_mux_reg.sv
module tb_ttl_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Four-channel instance (defaults)
  logic       reset4, load4, scan4, hold4, gn4;
  logic [7:0] in4;
  logic [1:0] sel4;
  logic [1:0] out4, ch4;
  logic       wrap4, err4;

  // Three-channel instance (range-check / odd wrap)
  logic       reset3, load3, scan3, hold3, gn3;
  logic [5:0] in3;
  logic [1:0] sel3;
  logic [1:0] out3, ch3;
  logic       wrap3, err3;

  ttl_mux_reg #(.WIDTH(2), .CHANNELS(4), .SEL_BITS(2)) u_dut4 (
    .clk(clk), .reset(reset4), .In(in4), .Sel(sel4), .Load(load4),
    .Scan(scan4), .Hold(hold4), .G_n(gn4),
    .Out(out4), .Ch(ch4), .Wrap(wrap4), .Err(err4)
  );

  ttl_mux_reg #(.WIDTH(2), .CHANNELS(3), .SEL_BITS(2)) u_dut3 (
    .clk(clk), .reset(reset3), .In(in3), .Sel(sel3), .Load(load3),
    .Scan(scan3), .Hold(hold3), .G_n(gn3),
    .Out(out3), .Ch(ch3), .Wrap(wrap3), .Err(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [1:0] e_out, input logic [1:0] e_ch,
                      input logic e_wrap, input logic e_err);
    check({tag, ".out"},  32'(out4),  32'(e_out));
    check({tag, ".ch"},   32'(ch4),   32'(e_ch));
    check({tag, ".wrap"}, 32'(wrap4), 32'(e_wrap));
    check({tag, ".err"},  32'(err4),  32'(e_err));
  endtask

  task automatic chk3(input string tag, input logic [1:0] e_out, input logic [1:0] e_ch,
                      input logic e_wrap, input logic e_err);
    check({tag, ".out"},  32'(out3),  32'(e_out));
    check({tag, ".ch"},   32'(ch3),   32'(e_ch));
    check({tag, ".wrap"}, 32'(wrap3), 32'(e_wrap));
    check({tag, ".err"},  32'(err3),  32'(e_err));
  endtask

  initial begin
    // ---------------- four-channel instance ----------------
    reset4 = 1'b1; in4 = 8'b10_11_01_10; sel4 = 2'd3; load4 = 1'b1;
    scan4 = 1'b1; hold4 = 1'b0; gn4 = 1'b0;
    reset3 = 1'b1; in3 = 6'b10_01_11; sel3 = 2'd0; load3 = 1'b0;
    scan3 = 1'b0; hold3 = 1'b0; gn3 = 1'b0;
    step();
    step();
    chk4("rst", 2'b00, 2'd0, 1'b0, 1'b0);

    reset4 = 1'b0; in4 = 8'b11_10_01_00; load4 = 1'b0; scan4 = 1'b0;
    step();
    chk4("post_rst", 2'b00, 2'd0, 1'b0, 1'b0);

    load4 = 1'b1; sel4 = 2'd2;
    step();
    chk4("load_e1", 2'b00, 2'd2, 1'b0, 1'b0);
    load4 = 1'b0;
    step();
    chk4("load_e2", 2'b10, 2'd2, 1'b0, 1'b0);

    scan4 = 1'b1;
    step(); chk4("scan1", 2'b10, 2'd3, 1'b0, 1'b0);
    step(); chk4("scan2", 2'b11, 2'd0, 1'b1, 1'b0);
    step(); chk4("scan3", 2'b00, 2'd1, 1'b0, 1'b0);
    step(); chk4("scan4", 2'b01, 2'd2, 1'b0, 1'b0);

    hold4 = 1'b1;
    step(); chk4("hold1", 2'b01, 2'd2, 1'b0, 1'b0);
    step(); chk4("hold2", 2'b01, 2'd2, 1'b0, 1'b0);

    hold4 = 1'b0; gn4 = 1'b1;
    step(); chk4("gn1", 2'b00, 2'd3, 1'b0, 1'b0);
    step(); chk4("gn2", 2'b00, 2'd0, 1'b1, 1'b0);
    gn4 = 1'b0;
    step(); chk4("gn_off1", 2'b00, 2'd1, 1'b0, 1'b0);
    step(); chk4("gn_off2", 2'b01, 2'd2, 1'b0, 1'b0);

    step(); chk4("pre_rst", 2'b10, 2'd3, 1'b0, 1'b0);
    reset4 = 1'b1;
    step(); chk4("mid_rst", 2'b00, 2'd0, 1'b0, 1'b0);
    reset4 = 1'b0;
    step(); chk4("resume1", 2'b00, 2'd1, 1'b0, 1'b0);
    step(); chk4("resume2", 2'b01, 2'd2, 1'b0, 1'b0);
    scan4 = 1'b0;

    // ---------------- three-channel instance ----------------
    // channels: ch0=11, ch1=01, ch2=10
    reset3 = 1'b0;
    load3 = 1'b1; sel3 = 2'd2;
    step(); chk3("r3_load2", 2'b11, 2'd2, 1'b0, 1'b0);
    sel3 = 2'd3;
    step(); chk3("r3_bad1", 2'b10, 2'd2, 1'b0, 1'b1);
    load3 = 1'b0;
    step(); chk3("r3_idle", 2'b10, 2'd2, 1'b0, 1'b0);
    load3 = 1'b1; scan3 = 1'b1;
    step(); chk3("r3_bad_scan", 2'b10, 2'd2, 1'b0, 1'b1);
    load3 = 1'b0;
    step(); chk3("r3_wrap", 2'b10, 2'd0, 1'b1, 1'b0);
    load3 = 1'b1; sel3 = 2'd1;
    step(); chk3("r3_load_scan", 2'b11, 2'd1, 1'b0, 1'b0);
    load3 = 1'b0; scan3 = 1'b0;
    step(); chk3("r3_out1", 2'b01, 2'd1, 1'b0, 1'b0);
    // A rejected load under Hold must not raise Err.
    hold3 = 1'b1; load3 = 1'b1; sel3 = 2'd3;
    step(); chk3("r3_hold_bad", 2'b01, 2'd1, 1'b0, 1'b0);
    hold3 = 1'b0; load3 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
